// File: rtl/assert_monitor.sv
// Capture stage for the two-counter assertion checker: timestamps the first
// violation after arming, snapshots both counters and offers the record over valid/ack.
module assert_monitor #(
  parameter int CW = 12,
  parameter int TW = 16,
  parameter int VW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          arm_i,
  input  logic          clr_i,
  input  logic          valid_i,
  input  logic [CW-1:0] count_i,
  input  logic [CW-1:0] count2_i,
  input  logic          fail_ack_i,
  output logic          armed_o,
  output logic          fail_o,
  output logic          fail_valid_o,
  output logic [TW-1:0] fail_cycle_o,
  output logic [CW-1:0] fail_count_o,
  output logic [CW-1:0] fail_count2_o,
  output logic [VW-1:0] viol_cnt_o,
  output logic          timeout_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_FAILED  = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_TIMEOUT = 3'd4;

  localparam logic [TW-1:0] CYC_MAX  = '1;
  localparam logic [VW-1:0] VIOL_MAX = '1;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] cyc_q, cyc_d;
  logic [TW-1:0] fcyc_q, fcyc_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [CW-1:0] fcnt2_q, fcnt2_d;
  logic [VW-1:0] viol_q, viol_d;
  logic          armed_q, fail_q, fvld_q, tout_q;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    fcyc_d  = fcyc_q;
    fcnt_d  = fcnt_q;
    fcnt2_d = fcnt2_q;
    viol_d  = viol_q;
    if (clr_i) begin
      state_d = S_IDLE;
      cyc_d   = '0;
      fcyc_d  = '0;
      fcnt_d  = '0;
      fcnt2_d = '0;
      viol_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm_i) begin
            state_d = S_ARMED;
            cyc_d   = '0;
          end
        end
        S_ARMED: begin
          // A violation on the last timestamp still wins over timeout.
          if (!valid_i) begin
            state_d = S_FAILED;
            fcyc_d  = cyc_q;
            fcnt_d  = count_i;
            fcnt2_d = count2_i;
            viol_d  = {{(VW-1){1'b0}}, 1'b1};
          end else if (cyc_q == CYC_MAX) begin
            state_d = S_TIMEOUT;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        S_FAILED, S_DONE: begin
          if (!valid_i && viol_q != VIOL_MAX) viol_d = viol_q + 1'b1;
          if (state_q == S_FAILED && fail_ack_i) state_d = S_DONE;
        end
        S_TIMEOUT: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      fcyc_q  <= '0;
      fcnt_q  <= '0;
      fcnt2_q <= '0;
      viol_q  <= '0;
      armed_q <= 1'b0;
      fail_q  <= 1'b0;
      fvld_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      fcyc_q  <= fcyc_d;
      fcnt_q  <= fcnt_d;
      fcnt2_q <= fcnt2_d;
      viol_q  <= viol_d;
      // Status flags are flopped from the next state so outputs stay registered.
      armed_q <= (state_d == S_ARMED);
      fail_q  <= (state_d == S_FAILED) || (state_d == S_DONE);
      fvld_q  <= (state_d == S_FAILED);
      tout_q  <= (state_d == S_TIMEOUT);
    end
  end

  assign armed_o       = armed_q;
  assign fail_o        = fail_q;
  assign fail_valid_o  = fvld_q;
  assign fail_cycle_o  = fcyc_q;
  assign fail_count_o  = fcnt_q;
  assign fail_count2_o = fcnt2_q;
  assign viol_cnt_o    = viol_q;
  assign timeout_o     = tout_q;

endmodule

// File: tb/tb_assert_monitor.sv
// Directed bench for assert_monitor with a short timestamp (TW=4) so the
// timeout boundary is reachable in a handful of cycles.
module tb_assert_monitor;
  localparam int CW = 12;
  localparam int TW = 4;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0, clr = 1'b0, valid = 1'b1, fail_ack = 1'b0;
  logic [CW-1:0] count = '0, count2 = '0;
  logic          armed, fail, fail_valid, timeout;
  logic [TW-1:0] fail_cycle;
  logic [CW-1:0] fail_count, fail_count2;
  logic [VW-1:0] viol_cnt;
  logic [4+TW+2*CW+VW-1:0] outs;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign outs = {armed, fail, fail_valid, timeout, fail_cycle, fail_count, fail_count2, viol_cnt};

  assert_monitor #(.CW(CW), .TW(TW), .VW(VW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .arm_i(arm), .clr_i(clr), .valid_i(valid),
    .count_i(count), .count2_i(count2), .fail_ack_i(fail_ack),
    .armed_o(armed), .fail_o(fail), .fail_valid_o(fail_valid),
    .fail_cycle_o(fail_cycle), .fail_count_o(fail_count), .fail_count2_o(fail_count2),
    .viol_cnt_o(viol_cnt), .timeout_o(timeout)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    arm = 1'b0; clr = 1'b0; valid = 1'b1; fail_ack = 1'b0; count = '0; count2 = '0;
  endtask

  task automatic do_clr();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    arm = 1'($urandom); clr = 1'($urandom); valid = 1'($urandom);
    fail_ack = 1'($urandom); count = 12'($urandom); count2 = 12'($urandom);
    step(3);
    checks++;
    if (outs !== '0) begin errs++; $display("FAIL reset_outs: got %h want 0", outs); end
    idle_inputs();
    valid = 1'b0;
    rst_n = 1'b1;
    step(3);
    checks++;
    if ({armed, fail, viol_cnt} !== '0) begin
      errs++; $display("FAIL reset_release: armed=%b fail=%b viol=%0d want all 0", armed, fail, viol_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_basic_capture();
    arm = 1'b1; step(); arm = 1'b0;
    checks++;
    if (armed !== 1'b1) begin errs++; $display("FAIL arm_latency: armed=%b want 1", armed); end
    valid = 1'b1; step(5);
    valid = 1'b0; count = 12'hFFF; count2 = 12'hFFF; step();
    valid = 1'b1; count = '0; count2 = '0;
    checks++;
    if ({fail, fail_valid, armed, fail_cycle, fail_count, fail_count2, viol_cnt} !==
        {1'b1, 1'b1, 1'b0, 4'd5, 12'hFFF, 12'hFFF, 8'd1}) begin
      errs++;
      $display("FAIL capture: fail=%b fv=%b armed=%b cyc=%0d c=%h c2=%h viol=%0d want 1 1 0 5 fff fff 1",
               fail, fail_valid, armed, fail_cycle, fail_count, fail_count2, viol_cnt);
    end
    step(2);
    checks++;
    if (fail_valid !== 1'b1) begin errs++; $display("FAIL fv_hold: fail_valid=%b want 1", fail_valid); end
    fail_ack = 1'b1; step(); fail_ack = 1'b0;
    checks++;
    if ({fail_valid, fail, fail_cycle} !== {1'b0, 1'b1, 4'd5}) begin
      errs++; $display("FAIL ack: fv=%b fail=%b cyc=%0d want 0 1 5", fail_valid, fail, fail_cycle);
    end
    do_clr();
  endtask

  task automatic test_saturation();
    arm = 1'b1; step(); arm = 1'b0;
    valid = 1'b1; step(2);
    valid = 1'b0; count = 12'h123; count2 = 12'h456; step();
    count = 12'h777; count2 = 12'h888;
    checks++;
    if ({fail_cycle, viol_cnt} !== {4'd2, 8'd1}) begin
      errs++; $display("FAIL sat_first: cyc=%0d viol=%0d want 2 1", fail_cycle, viol_cnt);
    end
    step(253);
    checks++;
    if (viol_cnt !== 8'd254) begin errs++; $display("FAIL sat_254: viol=%0d want 254", viol_cnt); end
    step();
    checks++;
    if (viol_cnt !== 8'd255) begin errs++; $display("FAIL sat_255: viol=%0d want 255", viol_cnt); end
    step(46);
    checks++;
    if ({viol_cnt, fail_cycle, fail_count, fail_count2} !== {8'd255, 4'd2, 12'h123, 12'h456}) begin
      errs++;
      $display("FAIL sat_hold: viol=%0d cyc=%0d c=%h c2=%h want 255 2 123 456",
               viol_cnt, fail_cycle, fail_count, fail_count2);
    end
    fail_ack = 1'b1; step(2); fail_ack = 1'b0;
    checks++;
    if ({fail_valid, fail, viol_cnt} !== {1'b0, 1'b1, 8'd255}) begin
      errs++; $display("FAIL done_sat: fv=%b fail=%b viol=%0d want 0 1 255", fail_valid, fail, viol_cnt);
    end
    do_clr();
    checks++;
    if (outs !== '0) begin errs++; $display("FAIL clr_done: got %h want 0", outs); end
    idle_inputs();
  endtask

  task automatic test_timeout();
    arm = 1'b1; step(); arm = 1'b0;
    valid = 1'b1; step(15);
    checks++;
    if ({timeout, armed} !== 2'b01) begin
      errs++; $display("FAIL tout_early: timeout=%b armed=%b want 0 1", timeout, armed);
    end
    step();
    checks++;
    if ({timeout, armed} !== 2'b10) begin
      errs++; $display("FAIL tout_16: timeout=%b armed=%b want 1 0", timeout, armed);
    end
    valid = 1'b0; step(3);
    checks++;
    if ({timeout, fail, fail_valid, viol_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      errs++; $display("FAIL tout_ignore: timeout=%b fail=%b fv=%b viol=%0d want 1 0 0 0",
                       timeout, fail, fail_valid, viol_cnt);
    end
    do_clr();
    idle_inputs();
  endtask

  task automatic test_timeout_edge_fail();
    arm = 1'b1; step(); arm = 1'b0;
    valid = 1'b1; step(15);
    valid = 1'b0; count = 12'h007; count2 = 12'h009; step();
    valid = 1'b1;
    checks++;
    if ({fail, timeout, fail_cycle, fail_count, fail_count2} !== {1'b1, 1'b0, 4'd15, 12'h007, 12'h009}) begin
      errs++; $display("FAIL edge_fail: fail=%b tout=%b cyc=%0d c=%h c2=%h want 1 0 15 007 009",
                       fail, timeout, fail_cycle, fail_count, fail_count2);
    end
    do_clr();
    idle_inputs();
  endtask

  task automatic test_priority();
    arm = 1'b1; step();
    clr = 1'b1; step(); clr = 1'b0; arm = 1'b0;
    checks++;
    if (outs !== '0) begin errs++; $display("FAIL clr_over_arm: got %h want 0", outs); end
    arm = 1'b1; step(); arm = 1'b0;
    valid = 1'b0; count = 12'h3C3; step();
    valid = 1'b1; count = '0;
    arm = 1'b1; step(2); arm = 1'b0;
    checks++;
    if ({armed, fail_valid, fail_cycle, fail_count} !== {1'b0, 1'b1, 4'd0, 12'h3C3}) begin
      errs++; $display("FAIL arm_in_failed: armed=%b fv=%b cyc=%0d c=%h want 0 1 0 3c3",
                       armed, fail_valid, fail_cycle, fail_count);
    end
    do_clr();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    arm = 1'b1; step(); arm = 1'b0;
    valid = 1'b1; step();
    valid = 1'b0; count = 12'hABC; count2 = 12'h111; step();
    valid = 1'b1;
    checks++;
    if (fail_valid !== 1'b1) begin errs++; $display("FAIL async_pre: fail_valid=%b want 1", fail_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin errs++; $display("FAIL async_rst: got %h want 0", outs); end
    #1 rst_n = 1'b1;
    step();
    arm = 1'b1; step(); arm = 1'b0;
    checks++;
    if (armed !== 1'b1) begin errs++; $display("FAIL rearm: armed=%b want 1", armed); end
    step(2);
    valid = 1'b0; count = 12'h055; step();
    valid = 1'b1;
    checks++;
    if ({fail_valid, fail_cycle, fail_count} !== {1'b1, 4'd2, 12'h055}) begin
      errs++; $display("FAIL rearm_capture: fv=%b cyc=%0d c=%h want 1 2 055", fail_valid, fail_cycle, fail_count);
    end
    do_clr();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_saturation();
    test_timeout();
    test_timeout_edge_fail();
    test_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
